// File: rtl/tl_pkg.sv
// tl_pkg: colour, lamp, fault and state encodings shared by the traffic lamp driver.
package tl_pkg;
  typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, RED = 2'd2, INVALID = 2'd3} colour_e;
  typedef enum logic [1:0] {FLT_NONE = 2'd0, FLT_CONFLICT = 2'd1, FLT_ILLEGAL = 2'd2, FLT_INVALID = 2'd3} fault_e;
  typedef enum logic [1:0] {UNPRIMED = 2'd0, NORMAL = 2'd1, FAULT = 2'd2} state_e;
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;
  function automatic logic [2:0] decode(input logic [1:0] c);
    return c == GREEN ? LAMP_GREEN : c == YELLOW ? LAMP_YELLOW : c == RED ? LAMP_RED : LAMP_OFF;
  endfunction
endpackage

// File: rtl/tl_seq_check.sv
// tl_seq_check: per-street previous colour and yellow-dwell tracking; flags illegal transitions.
module tl_seq_check
  import tl_pkg::*;
#(
  parameter int MIN_YELLOW = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_prime,
  input  logic       i_en,
  input  logic [1:0] i_colour,
  output logic       o_illegal
);
  localparam int CW = MIN_YELLOW > 1 ? $clog2(MIN_YELLOW + 1) : 1;
  localparam logic [CW-1:0] YMAX = CW'(MIN_YELLOW);
  logic [1:0] prev_q, prev_d;
  logic [CW-1:0] ycnt_q, ycnt_d;
  logic upd;
  assign upd = i_prime | i_en;
  always_comb begin
    o_illegal = (prev_q == GREEN && !(i_colour == GREEN || i_colour == YELLOW)) ||
                (prev_q == YELLOW && (i_colour == GREEN || (i_colour == RED && ycnt_q < YMAX))) ||
                (prev_q == RED && i_colour == YELLOW);
    prev_d = upd ? i_colour : prev_q;
    // counter restarts at 1 on any fresh yellow (including one captured while priming)
    ycnt_d = !upd ? ycnt_q :
             i_colour != YELLOW ? '0 :
             (i_prime || prev_q != YELLOW) ? CW'(1) :
             ycnt_q == YMAX ? ycnt_q : ycnt_q + 1'b1;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_q <= RED;
      ycnt_q <= '0;
    end else begin
      prev_q <= prev_d;
      ycnt_q <= ycnt_d;
    end
  end
endmodule

// File: rtl/traffic_lamp_driver.sv
// traffic_lamp_driver: decodes street colour codes to lamps, latching safety faults to forced red.
// Define TLD_FAULT_FLASH_EN to flash the forced red with BLINK_HALF-cycle half periods.
module traffic_lamp_driver
  import tl_pkg::*;
#(
  parameter int MIN_YELLOW = 1,
  parameter int BLINK_HALF = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_LA,
  input  logic [1:0] i_LB,
  input  logic       i_clr,
  output logic [2:0] o_lamp_A,
  output logic [2:0] o_lamp_B,
  output logic       o_fault,
  output logic [1:0] o_fault_code
);
  if (BLINK_HALF < 1) begin : g_bad_blink
    $error("BLINK_HALF must be at least 1");
  end
  state_e state_q, state_d;
  fault_e code_q, code_d, code_now;
  logic [2:0] lamp_a_q, lamp_a_d, lamp_b_q, lamp_b_d, flt_lamp;
  logic fault_q, fault_d, ill_a, ill_b, invalid, conflict, illegal, red_on;
  tl_seq_check #(.MIN_YELLOW(MIN_YELLOW)) u_chk_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_prime(state_q == UNPRIMED), .i_en(state_q == NORMAL),
    .i_colour(i_LA), .o_illegal(ill_a)
  );
  tl_seq_check #(.MIN_YELLOW(MIN_YELLOW)) u_chk_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_prime(state_q == UNPRIMED), .i_en(state_q == NORMAL),
    .i_colour(i_LB), .o_illegal(ill_b)
  );
  assign invalid  = i_LA == INVALID || i_LB == INVALID;
  assign conflict = i_LA != RED && i_LB != RED;
  assign illegal  = state_q == NORMAL && (ill_a || ill_b);
  assign code_now = invalid ? FLT_INVALID : conflict ? FLT_CONFLICT : illegal ? FLT_ILLEGAL : FLT_NONE;
`ifdef TLD_FAULT_FLASH_EN
  localparam int BW = BLINK_HALF > 1 ? $clog2(2 * BLINK_HALF) : 1;
  logic [BW-1:0] blink_q, blink_d;
  always_comb begin
    blink_d = state_q != FAULT ? '0 : blink_q == BW'(2 * BLINK_HALF - 1) ? '0 : blink_q + 1'b1;
    red_on = blink_d < BW'(BLINK_HALF);
  end
  always_ff @(posedge i_clk) blink_q <= i_rst ? '0 : blink_d;
`else
  assign red_on = 1'b1;
`endif
  always_comb begin
    state_d = state_q == FAULT ? ((i_clr && !invalid && !conflict) ? UNPRIMED : FAULT) :
              code_now != FLT_NONE ? FAULT : NORMAL;
  end
  always_comb begin
    fault_d  = state_d == FAULT;
    code_d   = state_q != FAULT ? code_now : state_d == FAULT ? code_q : FLT_NONE;
    flt_lamp = red_on ? LAMP_RED : LAMP_OFF;
    // the clearing cycle stays red; decode resumes from the priming sample
    lamp_a_d = state_d == FAULT ? flt_lamp : state_q == FAULT ? LAMP_RED : decode(i_LA);
    lamp_b_d = state_d == FAULT ? flt_lamp : state_q == FAULT ? LAMP_RED : decode(i_LB);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= UNPRIMED;
      code_q   <= FLT_NONE;
      fault_q  <= 1'b0;
      lamp_a_q <= LAMP_RED;
      lamp_b_q <= LAMP_RED;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      fault_q  <= fault_d;
      lamp_a_q <= lamp_a_d;
      lamp_b_q <= lamp_b_d;
    end
  end
  assign o_lamp_A     = lamp_a_q;
  assign o_lamp_B     = lamp_b_q;
  assign o_fault      = fault_q;
  assign o_fault_code = code_q;
endmodule

// File: tb/tb_traffic_lamp_driver.sv
// tb_traffic_lamp_driver: vector table plus corner sequences, checked through an expected-output queue.
module tb_traffic_lamp_driver;
  localparam int BH = 2;
`ifdef TLD_FAULT_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif
  localparam logic [1:0] G = 2'd0, Y = 2'd1, R = 2'd2, X = 2'd3;
  localparam logic [2:0] LR = 3'b100, LY = 3'b010, LG = 3'b001, LO = 3'b000;
  typedef struct {
    logic [1:0] la, lb;
    logic clr, rst;
    logic [2:0] ea, eb;
    logic ef;
    logic [1:0] ec;
  } vec_t;
  typedef struct {
    logic [2:0] ea, eb;
    logic ef;
    logic [1:0] ec;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic [1:0] la = R, lb = R, code;
  logic [2:0] lamp_a, lamp_b;
  logic fault;
  int applied = 0, miscompares = 0, fcnt = 0;
  exp_t q[$];
  vec_t v[$];
  traffic_lamp_driver #(.MIN_YELLOW(3), .BLINK_HALF(BH)) dut (
    .i_clk(clk), .i_rst(rst), .i_LA(la), .i_LB(lb), .i_clr(clr),
    .o_lamp_A(lamp_a), .o_lamp_B(lamp_b), .o_fault(fault), .o_fault_code(code)
  );
  always #5 clk = ~clk;
  task automatic step(input vec_t t);
    exp_t e, g;
    la = t.la; lb = t.lb; clr = t.clr; rst = t.rst;
    e.ea = t.ea; e.eb = t.eb; e.ef = t.ef; e.ec = t.ec;
    if (t.ef) begin
      if (FLASH && (fcnt % (2 * BH)) >= BH) begin
        e.ea = LO;
        e.eb = LO;
      end
      fcnt++;
    end else fcnt = 0;
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    applied++;
    if (lamp_a !== g.ea || lamp_b !== g.eb || fault !== g.ef || code !== g.ec) begin
      miscompares++;
      $display("FAIL vec%0d in A=%0d B=%0d clr=%b rst=%b: got lampA=%b lampB=%b fault=%b code=%0d, want lampA=%b lampB=%b fault=%b code=%0d",
               applied, t.la, t.lb, t.clr, t.rst, lamp_a, lamp_b, fault, code, g.ea, g.eb, g.ef, g.ec);
    end
  endtask
  initial begin
    v.push_back('{G, G, 1'b0, 1'b1, LR, LR, 1'b0, 2'd0});
    v.push_back('{G, R, 1'b0, 1'b0, LG, LR, 1'b0, 2'd0});
    v.push_back('{Y, R, 1'b0, 1'b0, LY, LR, 1'b0, 2'd0});
    v.push_back('{Y, R, 1'b0, 1'b0, LY, LR, 1'b0, 2'd0});
    v.push_back('{Y, R, 1'b0, 1'b0, LY, LR, 1'b0, 2'd0});
    v.push_back('{R, R, 1'b0, 1'b0, LR, LR, 1'b0, 2'd0});
    v.push_back('{R, G, 1'b0, 1'b0, LR, LG, 1'b0, 2'd0});
    v.push_back('{R, Y, 1'b0, 1'b0, LR, LY, 1'b0, 2'd0});
    v.push_back('{R, R, 1'b0, 1'b0, LR, LR, 1'b1, 2'd2});
    v.push_back('{G, G, 1'b0, 1'b0, LR, LR, 1'b1, 2'd2});
    v.push_back('{G, G, 1'b1, 1'b0, LR, LR, 1'b1, 2'd2});
    v.push_back('{R, G, 1'b1, 1'b0, LR, LR, 1'b0, 2'd0});
    v.push_back('{R, G, 1'b0, 1'b0, LR, LG, 1'b0, 2'd0});
    v.push_back('{G, G, 1'b0, 1'b0, LR, LR, 1'b1, 2'd1});
    v.push_back('{R, R, 1'b1, 1'b0, LR, LR, 1'b0, 2'd0});
    v.push_back('{G, R, 1'b0, 1'b0, LG, LR, 1'b0, 2'd0});
    v.push_back('{R, R, 1'b0, 1'b0, LR, LR, 1'b1, 2'd2});
    v.push_back('{R, R, 1'b1, 1'b1, LR, LR, 1'b0, 2'd0});
    v.push_back('{G, X, 1'b0, 1'b0, LR, LR, 1'b1, 2'd3});
    v.push_back('{G, G, 1'b0, 1'b0, LR, LR, 1'b1, 2'd3});
    v.push_back('{R, R, 1'b0, 1'b0, LR, LR, 1'b1, 2'd3});
    v.push_back('{R, R, 1'b1, 1'b0, LR, LR, 1'b0, 2'd0});
    v.push_back('{R, R, 1'b0, 1'b0, LR, LR, 1'b0, 2'd0});
    v.push_back('{R, G, 1'b0, 1'b0, LR, LG, 1'b0, 2'd0});
    v.push_back('{R, Y, 1'b0, 1'b0, LR, LY, 1'b0, 2'd0});
    v.push_back('{R, Y, 1'b0, 1'b0, LR, LY, 1'b0, 2'd0});
    v.push_back('{R, R, 1'b0, 1'b0, LR, LR, 1'b1, 2'd2});
    for (int i = 0; i < 4; i++) v.push_back('{R, R, 1'b0, 1'b0, LR, LR, 1'b1, 2'd2});
    for (int i = 0; i < v.size(); i++) step(v[i]);
    step('{R, R, 1'b0, 1'b1, LR, LR, 1'b0, 2'd0});
    step('{G, R, 1'b0, 1'b0, LG, LR, 1'b0, 2'd0});
    step('{Y, R, 1'b0, 1'b0, LY, LR, 1'b0, 2'd0});
    step('{G, R, 1'b0, 1'b0, LR, LR, 1'b1, 2'd2});
    step('{R, R, 1'b0, 1'b1, LR, LR, 1'b0, 2'd0});
    step('{R, R, 1'b0, 1'b0, LR, LR, 1'b0, 2'd0});
    step('{R, Y, 1'b0, 1'b0, LR, LR, 1'b1, 2'd2});
    step('{R, R, 1'b0, 1'b1, LR, LR, 1'b0, 2'd0});
    step('{G, R, 1'b0, 1'b0, LG, LR, 1'b0, 2'd0});
    step('{Y, R, 1'b0, 1'b0, LY, LR, 1'b0, 2'd0});
    step('{Y, R, 1'b0, 1'b1, LR, LR, 1'b0, 2'd0});
    step('{R, G, 1'b0, 1'b0, LR, LG, 1'b0, 2'd0});
    step('{X, R, 1'b0, 1'b0, LR, LR, 1'b1, 2'd3});
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule

// File: doc/traffic_lamp_driver.md
# traffic_lamp_driver

Receiving end of the traffic-light controller's colour-code outputs. Samples the two 2-bit colour codes (street A, street B) and decodes them into one-hot lamp drives. Checks every transition for safety and protocol legality; on any violation, latches a fault and forces both streets to red (optionally flashing) until cleared. Sits between the controller FSM and the physical lamp outputs.

## Interface
Parameters:
- MIN_YELLOW, 1: minimum consecutive cycles a street must show YELLOW before RED is legal.
- BLINK_HALF, 4: cycles per half-period of fault flashing (≥1).

Ports:
- i_clk  input  1  clock; single clock domain.
- i_rst  input  1  synchronous reset, active-high.
- i_LA  input  2  street A colour code: 0 GREEN, 1 YELLOW, 2 RED, 3 invalid.
- i_LB  input  2  street B colour code, same encoding.
- i_clr  input  1  request to clear a latched fault.
- o_lamp_A  output  3  street A lamps {red, yellow, green}, one-hot or all-off.
- o_lamp_B  output  3  street B lamps, same format.
- o_fault  output  1  fault latched.
- o_fault_code  output  2  0 none, 1 conflict, 2 illegal transition, 3 invalid code.

## Operation
- Top FSM states: UNPRIMED, NORMAL, FAULT.
- Reset:
  - o_lamp_A = o_lamp_B = 3'b100 (red).
  - o_fault = 0, o_fault_code = 0.
  - State = UNPRIMED; yellow counters = 0.
- UNPRIMED:
  - Captures current codes as previous colours. No transition check this cycle.
  - Invalid-code and conflict checks still apply.
  - Goes to NORMAL if no fault is detected; otherwise goes to FAULT.
- NORMAL: per street, the legal transitions are:
  - hold (same colour);
  - GREEN→YELLOW;
  - YELLOW→RED, only if the yellow counter ≥ MIN_YELLOW;
  - RED→GREEN.
  - Any other transition is illegal (code 2).
- Yellow counter (per street):
  - Set to 1 on entry to YELLOW.
  - Increments while YELLOW holds; saturates at MIN_YELLOW.
  - Cleared in any other colour.
- Conflict (code 1): both streets not RED in the same sample.
- Invalid (code 3): either input equals 3.
- Priority when several faults occur in one sample: invalid > conflict > illegal.
- FAULT:
  - o_fault = 1 and o_fault_code hold the first fault's code.
  - Lamps forced red per Configuration.
  - Later faults do not overwrite the code.
- Clear:
  - i_clr in FAULT with the current sample invalid-free and conflict-free: next state UNPRIMED, o_fault = 0, code = 0.
  - Otherwise FAULT is held.
  - i_clr in NORMAL or UNPRIMED has no effect.
- A faulty sample never reaches the lamps. Its cycle drives red on both streets.

## Timing
- Lamp latency is 1 cycle: the input sampled at edge N appears on the lamps after edge N.
- Fault detected on the sample at edge N: o_fault, o_fault_code, and forced red all appear after edge N, in the same cycle.
- Clear accepted at edge N: normal decode resumes from the sample at edge N+1 (UNPRIMED).
- i_rst asserted mid-fault or mid-yellow returns to reset values at the next edge; it dominates i_clr.
- The blink counter restarts at 0 on every FAULT entry.

## Configuration
- TLD_FAULT_FLASH_EN defined:
  - In FAULT, red is on for BLINK_HALF cycles, then all lamps are off for BLINK_HALF cycles, repeating.
  - The first faulted cycle shows red.
- TLD_FAULT_FLASH_EN undefined:
  - Steady red in FAULT.
  - Blink counter and BLINK_HALF logic are not compiled.

## Structure
- Shared package tl_pkg contains:
  - colour codes GREEN/YELLOW/RED/INVALID;
  - lamp one-hot constants LAMP_RED/LAMP_YELLOW/LAMP_GREEN/LAMP_OFF;
  - fault codes FLT_NONE/FLT_CONFLICT/FLT_ILLEGAL/FLT_INVALID;
  - top state encoding.
- Sub-module tl_seq_check, instantiated once per street:
  - holds the previous colour and yellow counter;
  - outputs an illegal-transition flag;
  - accepts a prime input that loads the previous colour without checking.

## Test plan
- Reset, then drive A:0,B:2 → 1 → 2; B:0: lamps A 001→010→100 and B 100→001, each 1 cycle late; o_fault stays 0.
- A:0,B:0 in NORMAL: next cycle both lamps 100, o_fault = 1, code 1.
- A GREEN→RED directly: code 2. Also, with MIN_YELLOW = 3, A YELLOW for 2 cycles then RED: code 2.
- Input 3 on B simultaneous with a conflict: code 3. A subsequent conflict does not change the code.
- Fault with TLD_FAULT_FLASH_EN and BLINK_HALF = 2: lamps 100,100,000,000,100… Without the macro: steady 100.
- i_clr with a conflicting sample: stays in FAULT. i_clr with A:2,B:0: fault clears next cycle and lamps follow the inputs. i_rst during FAULT: reset values.
